// File: rtl/mux_2to1_4bit_pkg.sv
// Shared definitions for the 2-to-1 nibble multiplexer.
//   DATA_WIDTH : default width of the data words (4 bits).
//   nibble_t   : 4-bit data word type used by the reference configuration.
package mux_2to1_4bit_pkg;

    localparam int unsigned DATA_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] nibble_t;

endpackage : mux_2to1_4bit_pkg

// File: rtl/mux_2to1_core.sv
// Parameterized combinational 2-to-1 selector.
// Ports:
//   a   : data word passed through when sel = 0
//   b   : data word passed through when sel = 1
//   sel : select, 0 -> a, 1 -> b
//   out : selected word, bit i taken from bit i of a or b
module mux_2to1_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Pure data-flow assignment: no clock or reset involvement.
    assign out = sel ? b : a;

endmodule : mux_2to1_core

// File: rtl/mux_2to1_4bit.sv
// 2-to-1 multiplexer for data words with a combinational result and a
// one-stage registered copy of that result.
// Ports:
//   clk     : clock, state updates on the rising edge
//   rst     : asynchronous active-high reset (clears out_q and valid_q)
//   a       : data word selected when sel = 0
//   b       : data word selected when sel = 1
//   sel     : select, 0 -> a, 1 -> b
//   out     : combinational mux result, independent of clk and rst
//   out_q   : registered mux result, one cycle behind out
//   valid_q : high once out_q holds a value sampled since reset
module mux_2to1_4bit
    import mux_2to1_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] mux_out;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .sel (sel),
        .out (mux_out)
    );

    assign out = mux_out;

    // The register samples the same selector output that drives out, so
    // out_q always equals the value out had just before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= mux_out;
            valid_q <= 1'b1;
        end
    end

endmodule : mux_2to1_4bit

// File: tb/tb_mux_2to1_4bit.sv
// Self-checking bench for mux_2to1_4bit: directed literal checks, an
// exhaustive sweep and randomized traffic against a behavioural model.
module tb_mux_2to1_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] out;
    logic [3:0] out_q;
    logic       valid_q;

    logic       clk_en;
    logic       chk_en;
    int         n_cmp;
    int         n_bad;

    // Behavioural model state: last sampled word and whether one exists.
    logic [3:0] model_q;
    logic       model_v;

    mux_2to1_4bit #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [3:0] pick(input logic [3:0] x, input logic [3:0] y,
                                        input logic s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = s ? y[i] : x[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: capture the selected word at each rising edge, clear on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q = 4'h0;
            model_v = 1'b0;
        end else begin
            model_q = pick(a, b, sel);
            model_v = 1'b1;
        end
    end

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out", out, pick(a, b, sel));
            check("out_q", out_q, model_q);
            check("valid_q", {3'b0, valid_q}, {3'b0, model_v});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pa [4];
        logic [3:0] pb [4];
        n_cmp   = 0;
        n_bad   = 0;
        clk_en  = 1'b0;
        chk_en  = 1'b0;
        model_q = 4'h0;
        model_v = 1'b0;
        a = 4'h0; b = 4'h0; sel = 1'b0;

        // Reset state with the clock idle.
        rst = 1'b1;
        #1;
        check("rst_out_q", out_q, 4'h0);
        check("rst_valid", {3'b0, valid_q}, 4'h0);
        rst = 1'b0;

        // sel = 0, clock idle.
        pa = '{4'h2, 4'h3, 4'h4, 4'h5};
        pb = '{4'h9, 4'hA, 4'hB, 4'hC};
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = pa[i]; b = pb[i];
            #20;
            check("sel0_out", out, pa[i]);
        end

        // sel = 1, clock idle; a changes must not reach out.
        sel = 1'b1;
        a = 4'h6; b = 4'hD; #20; check("sel1_out_D", out, 4'hD);
        a = 4'h7; b = 4'hE; #20; check("sel1_out_E", out, 4'hE);
        a = 4'h8; b = 4'hF; #20; check("sel1_out_F", out, 4'hF);
        a = 4'h1;           #20; check("sel1_a_ignored", out, 4'hF);
        check("idle_valid", {3'b0, valid_q}, 4'h0);

        // Clocked: reset pulse, then first edge loads D.
        rst = 1'b1; #1; rst = 1'b0;
        a = 4'h6; b = 4'hD; sel = 1'b1;
        #1;
        check("pre_edge_out_q", out_q, 4'h0);
        check("pre_edge_valid", {3'b0, valid_q}, 4'h0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("first_edge_out_q", out_q, 4'hD);
        check("first_edge_valid", {3'b0, valid_q}, 4'h1);
        chk_en = 1'b1;

        // Toggle sel between edges.
        @(negedge clk); #2;
        a = 4'h3; b = 4'hA; sel = 1'b0;
        #1; check("toggle_out_3", out, 4'h3); check("toggle_hold_q", out_q, 4'hD);
        sel = 1'b1;
        #1; check("toggle_out_A", out, 4'hA); check("toggle_hold_q2", out_q, 4'hD);
        @(posedge clk); #1;
        check("toggle_edge_q", out_q, 4'hA);

        // Async reset mid-run while out_q = F.
        @(negedge clk); #2;
        a = 4'h0; b = 4'hF; sel = 1'b1;
        @(posedge clk); #1;
        check("load_F", out_q, 4'hF);
        #1; rst = 1'b1;
        #1;
        check("async_rst_q", out_q, 4'h0);
        check("async_rst_valid", {3'b0, valid_q}, 4'h0);
        check("async_rst_out", out, 4'hF);
        @(negedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
        check("release_q", out_q, 4'hF);
        check("release_valid", {3'b0, valid_q}, 4'h1);

        // Exhaustive sweep; negedge comparator checks out and out_q.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(negedge clk); #2;
                    a = 4'(x); b = 4'(y); sel = s[0];
                end
            end
        end

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #2;
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            sel = 1'($urandom_range(1));
            if ($urandom_range(19) == 0) begin
                rst = 1'b1;
                #1;
                check("rand_rst_q", out_q, 4'h0);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_2to1_4bit
